// File: rtl/timer_counter3.sv
// Three-channel programmable down-counter (one-shot / rate / square), bus-written.
// Latency: writes and ticks update state in one clk; reads are combinational. No backpressure.
module timer_counter3 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter_we,
  input  logic [WIDTH-1:0] counter_val,
  input  logic [1:0]       counter_ch,
  input  logic             tick0,
  input  logic             tick1,
  input  logic             tick2,
  output logic [WIDTH-1:0] counter_out,
  output logic             counter0_out,
  output logic             counter1_out,
  output logic             counter2_out
);

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RATE    = 2'b01;
  localparam logic [1:0] MODE_SQUARE  = 2'b10;
  localparam logic [1:0] CH_CTRL      = 2'b11;

  logic [WIDTH-1:0] count  [3];
  logic [WIDTH-1:0] reload [3];
  logic [1:0]       mode   [3];
  logic [2:0]       gate;
  logic [2:0]       armed;
  logic [2:0]       out;
  logic [2:0]       tick;
  logic [2:0]       wr_reload;
  logic [2:0]       wr_ctrl;
  logic [2:0]       halted;
  logic [2:0]       dec_en;

  assign tick = {tick2, tick1, tick0};

  always_comb begin
    wr_reload = '0;
    wr_ctrl   = '0;
    halted    = '0;
    dec_en    = '0;
    for (int n = 0; n < 3; n++) begin
      wr_reload[n] = counter_we && (counter_ch == 2'(n));
      wr_ctrl[n]   = counter_we && (counter_ch == CH_CTRL) && (counter_val[7:6] == 2'(n));
      // Periodic modes with a zero reload would spin on the terminal event; hold instead.
      halted[n]    = (mode[n] != MODE_ONESHOT) && (reload[n] == '0);
      dec_en[n]    = armed[n] && gate[n] && tick[n] && !halted[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        count[n]  <= '0;
        reload[n] <= '0;
        mode[n]   <= MODE_ONESHOT;
      end
      gate  <= '0;
      armed <= '0;
      out   <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (wr_reload[n]) begin
          reload[n] <= counter_val;
          count[n]  <= counter_val;
          armed[n]  <= 1'b1;
          out[n]    <= 1'b0;
        end else if (wr_ctrl[n]) begin
          mode[n]  <= (counter_val[2:1] == 2'b11) ? MODE_ONESHOT : counter_val[2:1];
          gate[n]  <= counter_val[0];
          armed[n] <= 1'b0;
          out[n]   <= 1'b0;
        end else begin
          // Rate pulse is one cycle wide, independent of gate.
          if (mode[n] == MODE_RATE) begin
            out[n] <= 1'b0;
          end
          if (dec_en[n]) begin
            if (count[n] > WIDTH'(1)) begin
              count[n] <= count[n] - WIDTH'(1);
            end else begin
              case (mode[n])
                MODE_RATE: begin
                  count[n] <= reload[n];
                  out[n]   <= 1'b1;
                end
                MODE_SQUARE: begin
                  count[n] <= reload[n];
                  out[n]   <= ~out[n];
                end
                default: begin
                  count[n] <= '0;
                  out[n]   <= 1'b1;
                end
              endcase
            end
          end
        end
      end
    end
  end

  always_comb begin
    case (counter_ch)
      2'b00:   counter_out = count[0];
      2'b01:   counter_out = count[1];
      2'b10:   counter_out = count[2];
      default: counter_out = {{(WIDTH-6){1'b0}}, out, armed};
    endcase
  end

  assign counter0_out = out[0];
  assign counter1_out = out[1];
  assign counter2_out = out[2];

endmodule
